// File: rtl/io_pkg.sv
// Shared constants and width helper for the GPIO input-conditioning blocks.
package io_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 48000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  // Ceiling log2, usable in constant expressions; returns 0 for values <= 1.
  function automatic int unsigned clog2_width(input int unsigned value);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(value)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: synchroniser chain, stable-cycle debouncer and edge pulses.
module debounce_ch
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        INIT            = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = clog2_width(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt;

  assign sync_q = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{INIT}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_q;
        cnt   <= '0;
        rise  <= sync_q;
        fall  <= ~sync_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Bank of debounced GPIO inputs with maskable sticky edge flags and a combined irq.
module gpio_in_conditioner
  import io_pkg::*;
#(
  parameter int unsigned     N_CH            = 4,
  parameter int unsigned     SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned     DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [N_CH-1:0] INIT_LEVEL      = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  input  logic [N_CH-1:0] rise_en,
  input  logic [N_CH-1:0] fall_en,
  input  logic [N_CH-1:0] edge_clr,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] edge_flag,
  output logic            irq
);

  logic [N_CH-1:0] flag_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (INIT_LEVEL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_in[i]),
      .level(level_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i])
    );
  end

  // Set terms are OR-ed after the clear so a simultaneous set wins.
  always_comb begin
    flag_next = (rise_pulse & rise_en) | (fall_pulse & fall_en) | (edge_flag & ~edge_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_flag <= '0;
      irq       <= 1'b0;
    end else begin
      edge_flag <= flag_next;
      irq       <= |flag_next;
    end
  end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed self-checking bench for gpio_in_conditioner (N_CH=4, 2 sync stages, 4-cycle debounce).
module tb_gpio_in_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] raw_in;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic [3:0] edge_clr;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] edge_flag;
  logic       irq;

  int checks;
  int errors;

  gpio_in_conditioner #(
    .N_CH           (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .INIT_LEVEL     (4'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .edge_clr  (edge_clr),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .edge_flag (edge_flag),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges, leaving time 1 unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; raw_in = 4'hF; rise_en = 4'h0; fall_en = 4'h0; edge_clr = 4'h0;
    step(3);
    checks++;
    if ({level_out, rise_pulse, fall_pulse, edge_flag, irq} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got level=%h rise=%h fall=%h flag=%h irq=%b, want all 0",
               level_out, rise_pulse, fall_pulse, edge_flag, irq);
    end
    rst = 1'b0;
    step(5);
    checks++;
    if (level_out !== 4'h0) begin
      errors++; $display("FAIL reset_latency_early: level=%h want 0", level_out);
    end
    step(1);
    checks++;
    if (level_out !== 4'hF || rise_pulse !== 4'hF) begin
      errors++; $display("FAIL reset_latency_edge6: level=%h rise=%h want F F", level_out, rise_pulse);
    end
    step(1);
    checks++;
    if (level_out !== 4'hF || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) begin
      errors++; $display("FAIL reset_pulse_width: level=%h rise=%h fall=%h want F 0 0",
                         level_out, rise_pulse, fall_pulse);
    end
  endtask

  task automatic test_glitch;
    logic seen;
    raw_in = 4'h0;
    step(10);
    checks++;
    if (level_out !== 4'h0 || edge_flag !== 4'h0) begin
      errors++; $display("FAIL settle_low: level=%h flag=%h want 0 0", level_out, edge_flag);
    end
    seen = 1'b0;
    raw_in[0] = 1'b1;
    step(3);
    raw_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (level_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0) seen = 1'b1;
      step(1);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL glitch_reject: change seen=%b want 0", seen);
    end
    raw_in[0] = 1'b1;
    step(5);
    checks++;
    if (level_out[0] !== 1'b0) begin
      errors++; $display("FAIL hold_early: level0=%b want 0", level_out[0]);
    end
    step(1);
    checks++;
    if (level_out[0] !== 1'b1 || rise_pulse[0] !== 1'b1) begin
      errors++; $display("FAIL hold_edge6: level0=%b rise0=%b want 1 1", level_out[0], rise_pulse[0]);
    end
    step(1);
    checks++;
    if (rise_pulse[0] !== 1'b0) begin
      errors++; $display("FAIL hold_pulse_width: rise0=%b want 0", rise_pulse[0]);
    end
  endtask

  task automatic test_bounce;
    int pulses;
    pulses = 0;
    raw_in[1] = 1'b1; step(1);
    raw_in[1] = 1'b0; step(1);
    raw_in[1] = 1'b1;
    step(5);
    if (rise_pulse[1] === 1'b1) pulses++;
    checks++;
    if (level_out[1] !== 1'b0) begin
      errors++; $display("FAIL bounce_early: level1=%b want 0", level_out[1]);
    end
    step(1);
    if (rise_pulse[1] === 1'b1) pulses++;
    checks++;
    if (level_out[1] !== 1'b1) begin
      errors++; $display("FAIL bounce_edge6: level1=%b want 1", level_out[1]);
    end
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (rise_pulse[1] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL bounce_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_flags;
    raw_in = 4'b0010;
    step(10);
    rise_en = 4'h1; fall_en = 4'h2;
    raw_in = 4'b0001;
    step(10);
    checks++;
    if (edge_flag !== 4'h3 || irq !== 1'b1) begin
      errors++; $display("FAIL flag_set: flag=%h irq=%b want 3 1", edge_flag, irq);
    end
    raw_in = 4'b0101;
    step(10);
    checks++;
    if (level_out !== 4'h5 || edge_flag !== 4'h3) begin
      errors++; $display("FAIL flag_masked: level=%h flag=%h want 5 3", level_out, edge_flag);
    end
    edge_clr = 4'h1;
    step(1);
    edge_clr = 4'h0;
    checks++;
    if (edge_flag !== 4'h2 || irq !== 1'b1) begin
      errors++; $display("FAIL flag_clear: flag=%h irq=%b want 2 1", edge_flag, irq);
    end
  endtask

  task automatic test_collision;
    raw_in[0] = 1'b0;
    step(10);
    edge_clr = 4'h1;
    raw_in[0] = 1'b1;
    step(6);
    checks++;
    if (rise_pulse[0] !== 1'b1 || edge_flag[0] !== 1'b0) begin
      errors++; $display("FAIL collision_pulse: rise0=%b flag0=%b want 1 0", rise_pulse[0], edge_flag[0]);
    end
    step(1);
    edge_clr = 4'h0;
    checks++;
    if (edge_flag !== 4'h3 || irq !== 1'b1) begin
      errors++; $display("FAIL collision_set_wins: flag=%h irq=%b want 3 1", edge_flag, irq);
    end
  endtask

  task automatic test_mid_reset;
    raw_in[3] = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    checks++;
    if (level_out !== 4'h0 || edge_flag !== 4'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL midreset_async: level=%h flag=%h irq=%b want 0 0 0", level_out, edge_flag, irq);
    end
    step(2);
    rst = 1'b0;
    step(5);
    checks++;
    if (level_out[3] !== 1'b0) begin
      errors++; $display("FAIL midreset_early: level3=%b want 0", level_out[3]);
    end
    step(1);
    checks++;
    if (level_out !== 4'hD || rise_pulse !== 4'hD) begin
      errors++; $display("FAIL midreset_edge6: level=%h rise=%h want D D", level_out, rise_pulse);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_glitch();
    test_bounce();
    test_flags();
    test_collision();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
